// File: rtl/mem_bus_arbiter_if.sv
// Bus bundle between the two requesters (CPU, IOP), the arbiter and the
// single-port main memory.
//   cpu_* / iop_*   : per-master request, lock, address, byte enables, data,
//                     grant and read-valid strobe
//   memory_*        : muxed memory port plus the memory read data return
//   rd_data         : memory read data handed back to both masters
//   owner           : {cpu_gnt, iop_gnt} trace
// Modport slave is the arbiter side; master is the requester/memory side.
interface mem_bus_arbiter_if;
    logic         cpu_req;
    logic         cpu_lock;
    logic [15:31] cpu_address;
    logic [0:3]   cpu_write_en;
    logic [0:31]  cpu_data;
    logic         cpu_gnt;
    logic         cpu_rd_valid;

    logic         iop_req;
    logic         iop_lock;
    logic [15:31] iop_address;
    logic [0:3]   iop_write_en;
    logic [0:31]  iop_data;
    logic         iop_gnt;
    logic         iop_rd_valid;

    logic [15:31] memory_address;
    logic [0:3]   mem_write_en;
    logic [0:31]  memory_data_in;
    logic [0:31]  memory_data_out;
    logic [0:31]  rd_data;
    logic [1:0]   owner;

    modport slave (
        input  cpu_req, cpu_lock, cpu_address, cpu_write_en, cpu_data,
        input  iop_req, iop_lock, iop_address, iop_write_en, iop_data,
        input  memory_data_out,
        output cpu_gnt, cpu_rd_valid, iop_gnt, iop_rd_valid,
        output memory_address, mem_write_en, memory_data_in, rd_data, owner
    );

    modport master (
        output cpu_req, cpu_lock, cpu_address, cpu_write_en, cpu_data,
        output iop_req, iop_lock, iop_address, iop_write_en, iop_data,
        output memory_data_out,
        input  cpu_gnt, cpu_rd_valid, iop_gnt, iop_rd_valid,
        input  memory_address, mem_write_en, memory_data_in, rd_data, owner
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Two-master round-robin arbiter for the synchronous-read, byte-write-enabled
// main memory port. The grant is registered; the owner's address, byte enables
// and write data are muxed onto the memory port, and a read-valid strobe goes
// back to the master one cycle after each accepted read. A master asserting
// lock keeps the bus for up to MAX_HOLD consecutive cycles while the other
// master is waiting.
//   clock : system clock, all state on posedge
//   reset : synchronous, active high
//   bus   : mem_bus_arbiter_if.slave (master requests, memory port, strobes)
module mem_bus_arbiter #(
    parameter int MAX_HOLD   = 8,
    parameter bit RESET_LAST = 1'b0
) (
    input  logic              clock,
    input  logic              reset,
    mem_bus_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {G_NONE = 2'd0, G_CPU = 2'd1, G_IOP = 2'd2} grant_t;

    localparam logic [7:0] HOLD_MAX = 8'(MAX_HOLD - 1);

    grant_t     grant, grant_nxt;
    logic       last_served;   // 0 = CPU, 1 = IOP
    logic [7:0] hold_cnt;
    logic       cpu_rd_pend, iop_rd_pend;
    logic       cpu_acc, iop_acc, ls_eff;

    assign bus.cpu_gnt      = (grant == G_CPU);
    assign bus.iop_gnt      = (grant == G_IOP);
    assign bus.owner        = {bus.cpu_gnt, bus.iop_gnt};
    assign bus.cpu_rd_valid = cpu_rd_pend;
    assign bus.iop_rd_valid = iop_rd_pend;
    assign bus.rd_data      = bus.memory_data_out;

    assign cpu_acc = bus.cpu_gnt && bus.cpu_req;
    assign iop_acc = bus.iop_gnt && bus.iop_req;

    // The tie-break must see the access being accepted at this same edge,
    // otherwise an unlocked owner would win the next tie again.
    always_comb begin
        ls_eff = last_served;
        if (cpu_acc)      ls_eff = 1'b0;
        else if (iop_acc) ls_eff = 1'b1;
    end

    always_comb begin
        grant_nxt = G_NONE;
        case ({bus.cpu_req, bus.iop_req})
            2'b10: grant_nxt = G_CPU;
            2'b01: grant_nxt = G_IOP;
            2'b11: begin
                if (grant == G_CPU && bus.cpu_lock && hold_cnt < HOLD_MAX)
                    grant_nxt = G_CPU;
                else if (grant == G_IOP && bus.iop_lock && hold_cnt < HOLD_MAX)
                    grant_nxt = G_IOP;
                else
                    grant_nxt = ls_eff ? G_CPU : G_IOP;
            end
            default: grant_nxt = G_NONE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            grant       <= G_NONE;
            last_served <= RESET_LAST;
            hold_cnt    <= '0;
            cpu_rd_pend <= 1'b0;
            iop_rd_pend <= 1'b0;
        end else begin
            grant       <= grant_nxt;
            last_served <= ls_eff;
            if (grant_nxt != G_NONE && grant_nxt == grant)
                hold_cnt <= (hold_cnt == HOLD_MAX) ? hold_cnt : hold_cnt + 8'd1;
            else
                hold_cnt <= '0;
            cpu_rd_pend <= cpu_acc && (bus.cpu_write_en == 4'b0000);
            iop_rd_pend <= iop_acc && (bus.iop_write_en == 4'b0000);
        end
    end

    // Port mux. Byte enables are gated by the owner's req so a held grant
    // with no request never writes, and by reset so a write in flight when
    // reset hits is dropped.
    always_comb begin
        bus.memory_address = '0;
        bus.memory_data_in = '0;
        bus.mem_write_en   = '0;
        case (grant)
            G_CPU: begin
                bus.memory_address = bus.cpu_address;
                bus.memory_data_in = bus.cpu_data;
                if (bus.cpu_req) bus.mem_write_en = bus.cpu_write_en;
            end
            G_IOP: begin
                bus.memory_address = bus.iop_address;
                bus.memory_data_in = bus.iop_data;
                if (bus.iop_req) bus.mem_write_en = bus.iop_write_en;
            end
            default: ;
        endcase
        if (reset) bus.mem_write_en = '0;
    end

    a_gnt_onehot: assert property (@(posedge clock) disable iff (reset)
                                   !(bus.cpu_gnt && bus.iop_gnt));
endmodule

// File: tb/tb_mem_bus_arbiter.sv
module tb_mem_bus_arbiter;
    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    mem_bus_arbiter_if bus ();

    mem_bus_arbiter #(.MAX_HOLD(8), .RESET_LAST(1'b0)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // Memory model: synchronous read, big-endian byte lanes, plus a backdoor
    // preload port so all writes to the array come from one process.
    logic [0:31] mem [0:255];
    logic        bd_we;
    logic [7:0]  bd_addr;
    logic [0:31] bd_data;
    logic [7:0]  widx;
    assign widx = bus.memory_address[24:31];

    always @(posedge clock) begin
        if (bd_we) mem[bd_addr] <= bd_data;
        else
            for (int i = 0; i < 4; i++)
                if (bus.mem_write_en[i]) mem[widx][8*i +: 8] <= bus.memory_data_in[8*i +: 8];
        bus.memory_data_out <= mem[widx];
    end

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic sample;
        @(negedge clock);
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int          k, wait_cnt, max_wait;
    logic        acc;
    logic [1:0]  exp_own;

    initial begin
        reset = 1'b1;
        bus.cpu_req = 0; bus.cpu_lock = 0; bus.cpu_address = '0; bus.cpu_write_en = '0; bus.cpu_data = '0;
        bus.iop_req = 0; bus.iop_lock = 0; bus.iop_address = '0; bus.iop_write_en = '0; bus.iop_data = '0;
        bd_we = 1'b1; bd_addr = 8'd16; bd_data = 32'h1234_5678;
        tick;
        bd_addr = 8'd5;  bd_data = 32'h0000_0000;
        tick;
        bd_addr = 8'd40; bd_data = 32'hDEAD_BEEF;
        tick;
        bd_we = 1'b0;

        // Reset state
        sample;
        chk("rst_cpu_gnt", bus.cpu_gnt, 0);
        chk("rst_iop_gnt", bus.iop_gnt, 0);
        chk("rst_cpu_rdv", bus.cpu_rd_valid, 0);
        chk("rst_iop_rdv", bus.iop_rd_valid, 0);
        chk("rst_owner",   bus.owner, 0);
        chk("rst_we",      bus.mem_write_en, 0);
        chk("rst_addr",    bus.memory_address, 0);
        chk("rst_din",     bus.memory_data_in, 0);

        // 1: both request reads from release; IOP wins first, then alternate
        tick;
        reset = 1'b0;
        bus.cpu_req = 1; bus.cpu_address = 17'd1;
        bus.iop_req = 1; bus.iop_address = 17'd2;
        sample;
        chk("rr_owner_c0", bus.owner, 2'b00);
        for (int i = 0; i < 4; i++) begin
            tick;
            sample;
            chk($sformatf("rr_owner_c%0d", i + 1), bus.owner, (i % 2 == 0) ? 2'b01 : 2'b10);
            chk($sformatf("rr_addr_c%0d", i + 1), bus.memory_address, (i % 2 == 0) ? 2 : 1);
            chk($sformatf("rr_iop_rdv_c%0d", i + 1), bus.iop_rd_valid, (i % 2 == 1) ? 1 : 0);
            chk($sformatf("rr_cpu_rdv_c%0d", i + 1), bus.cpu_rd_valid, (i >= 2 && i % 2 == 0) ? 1 : 0);
        end
        tick;
        bus.cpu_req = 0; bus.iop_req = 0;
        tick;
        tick;

        // 2: lone IOP read of word 16
        bus.iop_req = 1; bus.iop_address = 17'h00010; bus.iop_write_en = 4'b0000;
        sample;
        chk("rd_gnt_lat", bus.iop_gnt, 0);
        tick;
        sample;
        chk("rd_gnt", bus.iop_gnt, 1);
        chk("rd_addr", bus.memory_address, 17'h00010);
        chk("rd_we", bus.mem_write_en, 0);
        tick;
        bus.iop_req = 0;
        sample;
        chk("rd_iop_rdv", bus.iop_rd_valid, 1);
        chk("rd_data", bus.rd_data, 32'h1234_5678);
        chk("rd_cpu_rdv", bus.cpu_rd_valid, 0);
        chk("rd_hold1", dut.hold_cnt, 1);
        tick;
        sample;
        chk("rd_rdv_once", bus.iop_rd_valid, 0);

        // 6: owner dropped req with the other idle -> released to NONE
        chk("rel_owner", bus.owner, 2'b00);
        chk("rel_addr", bus.memory_address, 0);
        chk("rel_we", bus.mem_write_en, 0);
        chk("rel_hold", dut.hold_cnt, 0);
        tick;

        // 4: CPU single-lane write to word 5
        bus.cpu_req = 1; bus.cpu_address = 17'd5; bus.cpu_write_en = 4'b0010; bus.cpu_data = 32'hAABB_CCDD;
        sample;
        chk("bw_we_nogrant", bus.mem_write_en, 0);
        tick;
        sample;
        chk("bw_gnt", bus.cpu_gnt, 1);
        chk("bw_we", bus.mem_write_en, 4'b0010);
        chk("bw_din", bus.memory_data_in, 32'hAABB_CCDD);
        tick;
        bus.cpu_req = 0;
        sample;
        chk("bw_gnt_held", bus.cpu_gnt, 1);
        chk("bw_we_noreq", bus.mem_write_en, 0);
        chk("bw_word5", mem[5], 32'h0000_CC00);
        chk("bw_no_rdv", bus.cpu_rd_valid, 0);
        tick;
        bus.cpu_write_en = 4'b0000; bus.cpu_data = '0;

        // 3: CPU locked burst of 20 writes vs. continuous IOP reads
        k = 0; wait_cnt = 0; max_wait = 0;
        bus.cpu_req = 1; bus.cpu_lock = 1; bus.cpu_write_en = 4'b1111;
        bus.cpu_address = 17'(100); bus.cpu_data = 32'hC0DE_0000;
        bus.iop_req = 1; bus.iop_address = 17'd2; bus.iop_write_en = 4'b0000;
        for (int c = 0; c < 24; c++) begin
            sample;
            exp_own = (c == 0) ? 2'b00 : (c == 1 || c == 10 || c == 19) ? 2'b01 : 2'b10;
            chk($sformatf("burst_owner_c%0d", c), bus.owner, exp_own);
            if (c == 9) chk("burst_hold_sat", dut.hold_cnt, 7);
            if (bus.iop_gnt) begin
                if (wait_cnt > max_wait) max_wait = wait_cnt;
                wait_cnt = 0;
            end else wait_cnt++;
            acc = bus.cpu_gnt && bus.cpu_req;
            tick;
            if (acc) k++;
            if (k < 20) begin
                bus.cpu_address = 17'(100 + k);
                bus.cpu_data    = 32'hC0DE_0000 + 32'(k);
            end else begin
                bus.cpu_req = 0; bus.cpu_lock = 0; bus.cpu_write_en = 4'b0000;
                bus.iop_req = 0;
            end
        end
        chk("burst_count", k, 20);
        chk("burst_iop_wait", (max_wait <= 8) ? 1 : 0, 1);
        tick;
        tick;
        for (int j = 0; j < 20; j++)
            chk($sformatf("burst_mem%0d", j), mem[100 + j], 32'hC0DE_0000 + 32'(j));

        // 5: reset during a granted IOP write with a CPU read pending
        bus.cpu_req = 1; bus.cpu_address = 17'd16; bus.cpu_write_en = 4'b0000;
        tick;
        bus.iop_req = 1; bus.iop_address = 17'd40; bus.iop_write_en = 4'b1111; bus.iop_data = 32'h1111_1111;
        sample;
        chk("mr_cpu_gnt", bus.cpu_gnt, 1);
        tick;
        reset = 1'b1;
        sample;
        chk("mr_iop_gnt", bus.iop_gnt, 1);
        chk("mr_we_forced", bus.mem_write_en, 0);
        tick;
        reset = 1'b0;
        sample;
        chk("mr_owner", bus.owner, 0);
        chk("mr_cpu_rdv", bus.cpu_rd_valid, 0);
        chk("mr_iop_rdv", bus.iop_rd_valid, 0);
        chk("mr_word40", mem[40], 32'hDEAD_BEEF);
        tick;
        sample;
        chk("mr_restart_iop", bus.owner, 2'b01);
        tick;
        bus.cpu_req = 0; bus.iop_req = 0; bus.iop_write_en = 4'b0000;
        tick;
        tick;
        chk("mr_word40_after", mem[40], 32'h1111_1111);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
